// File: rtl/qpro_run_ctrl.sv
// Batch run controller: launches RUNS unit runs back to back, measures per-run latency and reports pass/fail.
// Optional per-run watchdog compiled in with `define QPRO_RUN_CTRL_TIMEOUT_EN.
module qpro_run_ctrl #(
  parameter int unsigned RUNS           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  output logic        unit_start,
  input  logic        unit_done,
  input  logic        unit_err,
  output logic        busy,
  output logic [1:0]  status,
  output logic [7:0]  run_cnt,
  output logic [15:0] cycles
);

  if (RUNS < 1 || RUNS > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("qpro_run_ctrl: RUNS or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, GAP, DONE} state_t;

  localparam logic [7:0] RUNS_L = 8'(RUNS);

  state_t      state, state_nx;
  logic [15:0] lat;
  logic        fail_q;
  logic        in_run, accept_go, kill, done_ev, tmo_ev, last_run;
  logic [7:0]  run_cnt_inc;

  assign in_run      = (state == LAUNCH) || (state == WAIT) || (state == GAP);
  assign accept_go   = ((state == IDLE) || (state == DONE)) && go;
  assign kill        = in_run && abort;
  assign done_ev     = (state == WAIT) && unit_done && !abort;
  assign run_cnt_inc = run_cnt + 8'd1;
  assign last_run    = (run_cnt_inc >= RUNS_L);

`ifdef QPRO_RUN_CTRL_TIMEOUT_EN
  localparam logic [15:0] TMO_L = 16'(TIMEOUT_CYCLES);
  // A unit_done landing on the limit cycle wins over the watchdog.
  assign tmo_ev = (state == WAIT) && !unit_done && !abort && (lat == TMO_L);
`else
  assign tmo_ev = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = LAUNCH;
      LAUNCH:  state_nx = abort ? DONE : WAIT;
      WAIT: begin
        if (abort || tmo_ev)                    state_nx = DONE;
        else if (unit_done && (unit_err || last_run)) state_nx = DONE;
        else if (unit_done)                     state_nx = GAP;
      end
      GAP:     state_nx = abort ? DONE : LAUNCH;
      DONE:    if (go) state_nx = LAUNCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat     <= '0;
      run_cnt <= '0;
      cycles  <= '0;
      fail_q  <= 1'b0;
    end else begin
      if (accept_go) begin
        run_cnt <= '0;
        cycles  <= '0;
        fail_q  <= 1'b0;
      end
      if (state == LAUNCH) lat <= 16'd1;
      else if (state == WAIT && lat != '1) lat <= lat + 16'd1;
      if (done_ev) begin
        cycles  <= lat;
        run_cnt <= run_cnt_inc;
        fail_q  <= unit_err;
      end
      if (tmo_ev) begin
        cycles <= lat;
        fail_q <= 1'b1;
      end
      if (kill) fail_q <= 1'b1;
    end
  end

  always_comb begin
    unit_start = 1'b0;
    busy       = 1'b0;
    status     = 2'b00;
    case (state)
      LAUNCH: begin
        unit_start = 1'b1;
        busy       = 1'b1;
        status     = 2'b01;
      end
      WAIT, GAP: begin
        busy   = 1'b1;
        status = 2'b01;
      end
      DONE:    status = {1'b1, fail_q};
      default: status = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_qpro_run_ctrl.sv
// Randomized self-checking bench for qpro_run_ctrl against a per-batch outcome model.
`timescale 1ns/1ps
module tb_qpro_run_ctrl;
  localparam int RUNS = 4;
  localparam int TMO  = 8;
`ifdef QPRO_RUN_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0, unit_done = 1'b0, unit_err = 1'b0;
  logic unit_start, busy;
  logic [1:0] status;
  logic [7:0] run_cnt;
  logic [15:0] cycles;

  int n_vec = 0, n_err = 0;

  // batch configuration: per-run latency, per-run error, abort point, noise enable
  int dly[RUNS];
  bit er[RUNS];
  int ab_run, ab_lat;
  bit noise;

  int obs_starts, obs_gap_errs, obs_busy_errs, obs_launch_cnt, obs_launch_cyc;
  bit obs_hang;
  int exp_starts, exp_cnt, exp_cyc;
  logic [1:0] exp_stat;

  always #5 clk = ~clk;

  qpro_run_ctrl #(.RUNS(RUNS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .unit_start(unit_start), .unit_done(unit_done), .unit_err(unit_err),
    .busy(busy), .status(status), .run_cnt(run_cnt), .cycles(cycles)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Outcome of a whole batch from the run rules, walked run by run.
  task automatic model();
    exp_cnt = 0; exp_cyc = 0; exp_stat = 2'b11; exp_starts = 0;
    for (int i = 0; i < RUNS; i++) begin
      int lim;
      exp_starts = i + 1;
      lim = (TMO_EN && dly[i] > TMO) ? TMO : dly[i];
      if (ab_run == i && ab_lat <= lim) return;
      if (TMO_EN && dly[i] > TMO) begin exp_cyc = TMO; return; end
      exp_cnt++;
      exp_cyc = dly[i];
      if (er[i]) return;
    end
    exp_stat = 2'b10;
  endtask

  // Behaves as the controlled unit: answers each unit_start after dly[run] cycles.
  task automatic drive_batch();
    int k, run, since_end;
    bit in_run;
    obs_starts = 0; obs_gap_errs = 0; obs_busy_errs = 0; obs_hang = 1'b1;
    obs_launch_cnt = -1; obs_launch_cyc = -1;
    k = 0; run = -1; since_end = 0; in_run = 1'b0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      unit_done = 1'b0; unit_err = 1'b0; abort = 1'b0; go = 1'b0;
      if (!busy) begin obs_hang = 1'b0; break; end
      if (status !== 2'b01) obs_busy_errs++;
      if (!in_run) since_end++;
      if (unit_start) begin
        obs_starts++; run = obs_starts - 1; k = 0; in_run = 1'b1;
        if (obs_starts == 1) begin obs_launch_cnt = int'(run_cnt); obs_launch_cyc = int'(cycles); end
        else if (since_end != 2) obs_gap_errs++;
      end else if (in_run) k++;
      if (in_run && run < RUNS) begin
        if (noise) go = 1'b1;
        if (noise && k == 0) begin unit_done = 1'b1; unit_err = 1'b1; end
        if (k >= 1 && k == dly[run]) begin
          unit_done = 1'b1; unit_err = er[run]; in_run = 1'b0; since_end = 0;
        end
        if (ab_run == run && k == ab_lat) begin abort = 1'b1; in_run = 1'b0; end
      end else if (noise) begin
        unit_done = 1'b1; unit_err = 1'($urandom_range(0, 1)); go = 1'b1;
      end
      @(negedge clk);
    end
    unit_done = 1'b0; unit_err = 1'b0; abort = 1'b0; go = 1'b0;
    repeat (3) begin
      unit_done = noise; unit_err = noise;
      @(negedge clk);
    end
    unit_done = 1'b0; unit_err = 1'b0;
  endtask

  task automatic clear_cfg(input int d);
    for (int i = 0; i < RUNS; i++) begin dly[i] = d; er[i] = 1'b0; end
    ab_run = -1; ab_lat = 0; noise = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] got;
    rst_n = 1'b0; go = 1'b1;
    repeat (3) @(negedge clk);
    got = {unit_start, busy, status, run_cnt, cycles};
    n_vec++;
    if (got !== 28'd0) begin n_err++; $display("FAIL reset_values: got %h want 0", got); end
    rst_n = 1'b1; go = 1'b0;
    repeat (2) @(negedge clk);
    got = {unit_start, busy, status, run_cnt, cycles};
    n_vec++;
    if (got !== 28'd0) begin n_err++; $display("FAIL idle_after_release: got %h want 0", got); end
    unit_done = 1'b1; unit_err = 1'b1; abort = 1'b1;
    repeat (3) @(negedge clk);
    unit_done = 1'b0; unit_err = 1'b0; abort = 1'b0;
    got = {unit_start, busy, status, run_cnt, cycles};
    n_vec++;
    if (got !== 28'd0) begin n_err++; $display("FAIL idle_ignores_done: got %h want 0", got); end
  endtask

  task automatic run_and_check(input string name);
    logic [24:0] got_seq, exp_seq;
    logic [26:0] got_res, exp_res;
    model();
    drive_batch();
    got_seq = {obs_hang, 8'(obs_starts), 8'(obs_gap_errs), 8'(obs_busy_errs)};
    exp_seq = {1'b0, 8'(exp_starts), 8'd0, 8'd0};
    n_vec++;
    if (got_seq !== exp_seq) begin
      n_err++;
      $display("FAIL %s_seq: hang/starts/gap_err/busy_err got %h want %h", name, got_seq, exp_seq);
    end
    got_res = {busy, status, run_cnt, cycles};
    exp_res = {1'b0, exp_stat, 8'(exp_cnt), 16'(exp_cyc)};
    n_vec++;
    if (got_res !== exp_res) begin
      n_err++;
      $display("FAIL %s_result: busy/status/run_cnt/cycles got %h want %h", name, got_res, exp_res);
    end
  endtask

  task automatic test_pass();
    clear_cfg(3);
    run_and_check("pass4");
    n_vec++;
    if (obs_launch_cnt !== 0 || obs_launch_cyc !== 0) begin
      n_err++; $display("FAIL first_launch_clear: cnt %0d cyc %0d want 0 0", obs_launch_cnt, obs_launch_cyc);
    end
  endtask

  task automatic test_err();
    clear_cfg(3);
    dly[0] = 5; er[1] = 1'b1;
    run_and_check("err_run2");
  endtask

  task automatic test_abort_done();
    clear_cfg(2);
    dly[1] = 4; ab_run = 1; ab_lat = 4;
    run_and_check("abort_with_done");
    clear_cfg(6);
    ab_run = 0; ab_lat = 0;
    run_and_check("abort_in_launch");
  endtask

  task automatic test_back_to_back();
    clear_cfg(5);
    run_and_check("b2b_first");
    clear_cfg(1);
    noise = 1'b1;
    run_and_check("b2b_second");
    n_vec++;
    if (obs_launch_cnt !== 0 || obs_launch_cyc !== 0) begin
      n_err++; $display("FAIL b2b_go_clears: cnt %0d cyc %0d want 0 0", obs_launch_cnt, obs_launch_cyc);
    end
  endtask

`ifdef QPRO_RUN_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    clear_cfg(100);
    run_and_check("timeout");
    clear_cfg(TMO);
    run_and_check("timeout_tie");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < RUNS; i++) begin
        dly[i] = $urandom_range(1, 12);
        er[i]  = ($urandom_range(0, 7) == 0);
      end
      ab_run = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, RUNS - 1)) : -1;
      ab_lat = $urandom_range(0, 12);
      noise  = 1'($urandom_range(0, 1));
      run_and_check("random");
    end
  endtask

  task automatic test_midreset();
    logic [27:0] got;
    int starts_seen;
    bit busy_seen, saw_start;
    clear_cfg(50);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    saw_start = 1'b0;
    for (int t = 0; t < 10 && !saw_start; t++) begin
      if (unit_start) saw_start = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (!saw_start) begin n_err++; $display("FAIL midreset_start: no unit_start within 10 cycles"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 got = {unit_start, busy, status, run_cnt, cycles};
    n_vec++;
    if (got !== 28'd0) begin n_err++; $display("FAIL midreset_async: got %h want 0", got); end
    starts_seen = 0; busy_seen = 1'b0;
    @(negedge clk); unit_done = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (unit_start) starts_seen++;
      if (busy) busy_seen = 1'b1;
    end
    unit_done = 1'b0;
    n_vec++;
    if (starts_seen != 0 || busy_seen || status !== 2'b00) begin
      n_err++; $display("FAIL midreset_quiet: starts %0d busy %0b status %b want 0 0 00", starts_seen, busy_seen, status);
    end
    clear_cfg(2);
    run_and_check("after_reset");
    n_vec++;
    if (obs_launch_cnt !== 0) begin n_err++; $display("FAIL after_reset_cnt: got %0d want 0", obs_launch_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_err();
    test_abort_done();
    test_back_to_back();
`ifdef QPRO_RUN_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
